// File: rtl/drv_pwm.sv
// Dead-time-protected complementary PWM driver: 2048-clock period, duty latched
// from drv_mag[11:1] once per period, Moore FSM with guaranteed off-gap at every switch.
module drv_pwm #(
  parameter int DEADTIME = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] drv_mag,
  input  logic        en,
  output logic [10:0] duty_lat,
  output logic        PWM_synch,
  output logic        high_side,
  output logic        low_side
);

  typedef enum logic [1:0] {IDLE, DEAD, HI, LO} state_t;

  localparam logic [7:0] DEAD_LOAD = 8'(DEADTIME - 1);

  state_t      state_reg;
  logic [10:0] cnt_reg;
  logic [7:0]  dcnt_reg;
  logic        pwm_raw;
  logic        unused_mag_lsb;

  // Only the upper 11 bits of the PID magnitude carry duty resolution.
  assign unused_mag_lsb = drv_mag[0];

  assign PWM_synch = (cnt_reg == 11'h7FF);
  assign pwm_raw   = (cnt_reg < duty_lat);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg  <= '0;
      duty_lat <= '0;
    end else begin
      cnt_reg <= cnt_reg + 11'd1;
      if (PWM_synch)
        duty_lat <= drv_mag[11:1];
    end
  end

  // Outputs are registered alongside the state so they always equal (state==HI/LO).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      dcnt_reg  <= '0;
      high_side <= 1'b0;
      low_side  <= 1'b0;
    end else if (!en) begin
      state_reg <= IDLE;
      high_side <= 1'b0;
      low_side  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          state_reg <= DEAD;
          dcnt_reg  <= DEAD_LOAD;
        end
        DEAD: begin
          if (dcnt_reg != 8'd0) begin
            dcnt_reg <= dcnt_reg - 8'd1;
          end else if (pwm_raw) begin
            state_reg <= HI;
            high_side <= 1'b1;
          end else begin
            state_reg <= LO;
            low_side  <= 1'b1;
          end
        end
        HI: begin
          if (!pwm_raw) begin
            state_reg <= DEAD;
            dcnt_reg  <= DEAD_LOAD;
            high_side <= 1'b0;
          end
        end
        LO: begin
          if (pwm_raw) begin
            state_reg <= DEAD;
            dcnt_reg  <= DEAD_LOAD;
            low_side  <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          high_side <= 1'b0;
          low_side  <= 1'b0;
        end
      endcase
    end
  end

endmodule
